// File: rtl/ggt_stein.sv
// ---------------------------------------------------------------------------
// ggt_stein -- binary (Stein) greatest-common-divisor responder.
//
// Takes one subtract-or-shift step per clock and has no divider. It uses the
// same start/valid handshake as the Euclid core ggt_top, so it can replace
// that core directly.
//
// Parameters
//   WIDTH  operand and result width in bits
//   CNTW   width of the common-power-of-two counter k (2**CNTW > WIDTH)
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst_i       asynchronous reset, active high
//   start_i     request; only looked at in IDLE and DONE
//   Zahl1_i     operand a, captured when start_i is accepted
//   Zahl2_i     operand b, captured when start_i is accepted
//   valid_o     result valid; a level held until the next accepted start
//   ergebnis_o  gcd(a,b); stable while valid_o is high
//   busy_o      high in every state except IDLE and DONE
//   zyklen_o    (only with GGT_CYCLE_COUNT_EN) number of cycles from start
//               acceptance to DONE entry, saturating, held with ergebnis_o
//
// Build option
//   GGT_CYCLE_COUNT_EN  when defined, adds the zyklen_o port and the
//                       latency counter behind it.
// ---------------------------------------------------------------------------
module ggt_stein #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ergebnis_o,
    output logic             busy_o
`ifdef GGT_CYCLE_COUNT_EN
    ,
    output logic [15:0]      zyklen_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SHIFT  = 3'd2,
        S_NORM   = 3'd3,
        S_REDUCE = 3'd4,
        S_FIX    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNTW-1:0]  k_q, k_d;
    logic [WIDTH-1:0] ergebnis_q, ergebnis_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             start_ok_s;

    // A start counts only while the core is idle or holding a result.
    assign start_ok_s = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    // State register.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CHECK;
                else         state_d = S_IDLE;
            end
            S_CHECK: begin
                if ((a_q == ZERO_W) || (b_q == ZERO_W)) state_d = S_DONE;
                else                                    state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (a_q[0] || b_q[0]) state_d = S_NORM;
                else                  state_d = S_SHIFT;
            end
            S_NORM: begin
                if (a_q[0]) state_d = S_REDUCE;
                else        state_d = S_NORM;
            end
            S_REDUCE: begin
                if (b_q == ZERO_W) state_d = S_FIX;
                else               state_d = S_REDUCE;
            end
            S_FIX: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start_i) state_d = S_CHECK;
                else         state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: operand capture, Stein steps, result capture.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        ergebnis_d = ergebnis_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_d = Zahl1_i;
                    b_d = Zahl2_i;
                    k_d = {CNTW{1'b0}};
                end else begin
                    a_d = a_q;
                end
            end
            S_CHECK: begin
                // A zero operand makes the other one the answer: gcd(0,x)=x.
                if (a_q == ZERO_W) begin
                    ergebnis_d = b_q;
                end else if (b_q == ZERO_W) begin
                    ergebnis_d = a_q;
                end else begin
                    k_d = {CNTW{1'b0}};
                end
            end
            S_SHIFT: begin
                // Strip common factors of two and count them in k.
                if (!(a_q[0] || b_q[0])) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + {{(CNTW-1){1'b0}}, 1'b1};
                end else begin
                    k_d = k_q;
                end
            end
            S_NORM: begin
                // Make a odd; b may still be even, which REDUCE handles.
                if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else begin
                    a_d = a_q;
                end
            end
            S_REDUCE: begin
                // a stays odd: it is only replaced by an odd b. Both
                // subtractions take the larger operand as the minuend.
                if (b_q == ZERO_W) begin
                    b_d = b_q;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = b_q;
                    b_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            S_FIX: begin
                // Put back the common power of two. The result never
                // exceeds either input, so the shift cannot overflow.
                ergebnis_d = a_q << k_q;
            end
            default: begin
                a_d = a_q;
            end
        endcase
    end

    // Output decode: valid follows DONE one cycle later, busy tracks the
    // next state so that it rises on the accepting edge.
    always_comb begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if ((state_q == S_DONE) && !start_i) begin
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            busy_d = 1'b0;
        end else begin
            busy_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            a_q        <= ZERO_W;
            b_q        <= ZERO_W;
            k_q        <= {CNTW{1'b0}};
            ergebnis_q <= ZERO_W;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            ergebnis_q <= ergebnis_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign valid_o    = valid_q;
    assign ergebnis_o = ergebnis_q;
    assign busy_o     = busy_q;

`ifdef GGT_CYCLE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] zyklen_q, zyklen_d;
    logic [15:0] cnt_inc_s;

    // Saturating increment of the running cycle count.
    always_comb begin
        if (cnt_q == 16'hFFFF) cnt_inc_s = cnt_q;
        else                   cnt_inc_s = cnt_q + 16'd1;
    end

    // Count from the accepting edge and latch the total when DONE is entered.
    always_comb begin
        cnt_d    = cnt_q;
        zyklen_d = zyklen_q;
        if (start_ok_s) begin
            cnt_d = 16'd0;
        end else if ((state_q != S_IDLE) && (state_q != S_DONE)) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
        if ((state_q != S_DONE) && (state_d == S_DONE)) begin
            zyklen_d = cnt_inc_s;
        end else begin
            zyklen_d = zyklen_q;
        end
    end

    // Cycle counter registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= 16'd0;
            zyklen_q <= 16'd0;
        end else begin
            cnt_q    <= cnt_d;
            zyklen_q <= zyklen_d;
        end
    end

    assign zyklen_o = zyklen_q;
`else
    logic unused_start_ok_s;
    assign unused_start_ok_s = start_ok_s;
`endif

endmodule

// File: doc/ggt_stein.md
Name: ggt_stein

Overview:
- Binary (Stein) GCD responder with the same start/valid handshake as the Euclid core `ggt_top`.
- Drop-in alternative for `ggt_top`: the existing file-driven testbench and the FPGA wrapper drive it unchanged.
- One subtract-or-shift step per cycle, no divider. Used to compare area and latency against the Euclid variant.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CNTW, 5, width of the common-power-of-two counter k. Must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- start_i  input  1  request. Sampled in IDLE and DONE only.
- Zahl1_i  input  WIDTH  operand a, captured when start_i is accepted.
- Zahl2_i  input  WIDTH  operand b, captured when start_i is accepted.
- valid_o  output  1  result valid, level, held until the next accepted start.
- ergebnis_o  output  WIDTH  gcd(a,b), stable while valid_o=1.
- busy_o  output  1  high in every state except IDLE and DONE.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; a, b, k cleared; valid_o=0, ergebnis_o=0, busy_o=0.
  - Any computation in flight is discarded.
- Start acceptance:
  - start_i=1 in IDLE or DONE captures the operands, clears valid_o on the next edge and enters CHECK.
  - start_i is ignored in all other states. There is no queueing.
  - start_i held high across DONE restarts immediately with the currently applied operands.
- CHECK (1 cycle):
  - if a=0 → result=b, go to DONE.
  - else if b=0 → result=a, go to DONE.
  - else k=0, go to SHIFT.
  - gcd(0,0)=0.
- SHIFT: while a and b are both even, a>>=1, b>>=1, k+=1, one per cycle. When either is odd → NORM.
- NORM: while a is even, a>>=1, one per cycle. When a is odd → REDUCE.
- REDUCE, one action per cycle, priority in this order:
  - if b=0 → FIX.
  - else if b is even → b>>=1.
  - else if a>b → a<=b, b<=a-b, in the same cycle.
  - else → b<=b-a.
  - Invariant: a is odd in REDUCE.
  - All arithmetic is unsigned WIDTH-bit with no wrap; subtraction is only ever taken with minuend ≥ subtrahend.
- FIX (1 cycle): result=a<<k, truncated to WIDTH. No overflow is possible since result ≤ min(a_in,b_in).
- DONE:
  - valid_o=1, ergebnis_o=result, held.
  - Stay in DONE until start_i.
- Latency: start edge to valid_o=1 is at most 4*WIDTH+4 cycles, and exactly 2 cycles when either operand is 0.
- ergebnis_o changes only on entry to DONE or on reset.

Optional Feature:
- Macro GGT_CYCLE_COUNT_EN:
  - Defined: adds output zyklen_o, width 16. Counts clock cycles from start acceptance to DONE entry (saturating at 16'hFFFF). The value is latched on DONE entry and held alongside ergebnis_o; reset value 0. Used for the Euclid/Stein latency comparison.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- (24255, 12540), start for 1 cycle → valid_o rises within 68 cycles; ergebnis_o=165, held until next start.
- (0,0) → 0; (0,42) → 42; (42,0) → 42; each with valid_o exactly 2 cycles after the start edge.
- (48,18) → 6; (32768,16384) → 16384 (k=14 path); (65535,65535) → 65535; (1,65535) → 1.
- Pulse start_i with (100,75) while busy_o=1 during the (24255,12540) run → ignored; result 165.
- Assert rst_i mid-REDUCE → valid_o=0, ergebnis_o=0, busy_o=0 asynchronously. A following start with (12,18) → 6.
- File-driven loop of 1000 random pairs, compared against the Euclid core's output file → all match. With GGT_CYCLE_COUNT_EN, zyklen_o ≤ 68 for every pair.
